// File: rtl/pll_dyn_ctrl.sv
// Reset, lock qualification and dynamic divider sequencer for the rPLL.
// Everything runs in the clkin domain; all outputs are registered.
module pll_dyn_ctrl #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 100000,
  parameter int LOCK_STABLE  = 64,
  parameter int MAX_RETRY    = 3,
  parameter logic [5:0] INIT_IDSEL  = 6'd0,
  parameter logic [5:0] INIT_FBDSEL = 6'd0,
  parameter logic [5:0] INIT_ODSEL  = 6'd0
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       cfg_valid,
  output logic       cfg_ready,
  input  logic [5:0] cfg_idsel,
  input  logic [5:0] cfg_fbdsel,
  input  logic [5:0] cfg_odsel,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] pll_idsel,
  output logic [5:0] pll_fbdsel,
  output logic [5:0] pll_odsel,
  output logic       locked,
  output logic       busy,
  output logic       err,
  output logic [7:0] relock_cnt
);

  localparam int HW = $clog2(RST_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int SW = $clog2(LOCK_STABLE + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);

  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(LOCK_TIMEOUT - 1);
  localparam logic [SW-1:0] STB_LAST  = SW'(LOCK_STABLE - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_HOLD,
    S_WAIT,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t state, state_nxt;

  logic          lock_m, lock_s;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [TW-1:0] tmo_cnt, tmo_nxt;
  logic [SW-1:0] stb_cnt, stb_nxt;
  logic [RW-1:0] retry, retry_nxt;
  logic [7:0]    relock_nxt;
  logic          accept, latch;
  logic          pend;
  logic [5:0]    id_q, fb_q, od_q;

  assign accept = cfg_valid & cfg_ready;

  // LOCK comes straight from the analog macro
  always_ff @(posedge clkin) begin
    if (reset) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= pll_lock;
      lock_s <= lock_m;
    end
  end

  always_comb begin
    state_nxt  = state;
    hold_nxt   = hold_cnt;
    tmo_nxt    = tmo_cnt;
    stb_nxt    = stb_cnt;
    retry_nxt  = retry;
    relock_nxt = relock_cnt;
    latch      = 1'b0;
    unique case (state)
      S_HOLD: begin
        hold_nxt = hold_cnt + 1'b1;
        if (hold_cnt == HOLD_LAST) begin
          state_nxt = S_WAIT;
          hold_nxt  = '0;
          tmo_nxt   = '0;
        end
      end
      S_WAIT, S_STABLE: begin
        tmo_nxt = tmo_cnt + 1'b1;
        if (tmo_cnt == TMO_LAST) begin
          retry_nxt = retry + 1'b1;
          hold_nxt  = '0;
          state_nxt = (retry_nxt < RETRY_MAX) ? S_HOLD : S_FAIL;
        end else if (state == S_WAIT) begin
          if (lock_s) begin
            state_nxt = S_STABLE;
            stb_nxt   = '0;
          end
        end else if (!lock_s) begin
          state_nxt = S_WAIT;
        end else if (stb_cnt == STB_LAST) begin
          state_nxt = S_RUN;
          retry_nxt = '0;
        end else begin
          stb_nxt = stb_cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (!lock_s && relock_cnt != 8'hFF)
          relock_nxt = relock_cnt + 8'd1;
        latch = accept;
        if (!lock_s || accept) begin
          state_nxt = S_HOLD;
          hold_nxt  = '0;
        end
      end
      S_FAIL: begin
        if (accept) begin
          latch     = 1'b1;
          retry_nxt = '0;
          state_nxt = S_HOLD;
          hold_nxt  = '0;
        end
      end
      default: begin
        state_nxt = S_HOLD;
        hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clkin) begin
    if (reset) begin
      state <= S_HOLD;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs are decoded from the next state so they line up with it
  always_ff @(posedge clkin) begin
    if (reset) begin
      hold_cnt   <= '0;
      tmo_cnt    <= '0;
      stb_cnt    <= '0;
      retry      <= '0;
      relock_cnt <= 8'd0;
      pend       <= 1'b0;
      id_q       <= INIT_IDSEL;
      fb_q       <= INIT_FBDSEL;
      od_q       <= INIT_ODSEL;
      pll_idsel  <= INIT_IDSEL;
      pll_fbdsel <= INIT_FBDSEL;
      pll_odsel  <= INIT_ODSEL;
      pll_reset  <= 1'b1;
      locked     <= 1'b0;
      busy       <= 1'b1;
      err        <= 1'b0;
      cfg_ready  <= 1'b0;
    end else begin
      hold_cnt   <= hold_nxt;
      tmo_cnt    <= tmo_nxt;
      stb_cnt    <= stb_nxt;
      retry      <= retry_nxt;
      relock_cnt <= relock_nxt;
      if (latch) begin
        pend <= 1'b1;
        id_q <= cfg_idsel;
        fb_q <= cfg_fbdsel;
        od_q <= cfg_odsel;
      end else if (state == S_HOLD && hold_cnt == '0 && pend) begin
        pend       <= 1'b0;
        pll_idsel  <= id_q;
        pll_fbdsel <= fb_q;
        pll_odsel  <= od_q;
      end
      pll_reset <= (state_nxt == S_HOLD) || (state_nxt == S_FAIL);
      locked    <= (state_nxt == S_RUN);
      busy      <= (state_nxt == S_HOLD) || (state_nxt == S_WAIT) ||
                   (state_nxt == S_STABLE);
      err       <= (state_nxt == S_FAIL);
      cfg_ready <= (state_nxt == S_RUN) || (state_nxt == S_FAIL);
    end
  end

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Scoreboard bench for pll_dyn_ctrl with a behavioural rPLL LOCK model.
// Stimulus queues expected events; a negedge monitor pops and compares.
module tb_pll_dyn_ctrl;

  logic       clkin = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [5:0] cfg_idsel = '0;
  logic [5:0] cfg_fbdsel = '0;
  logic [5:0] cfg_odsel = '0;
  logic       pll_lock = 1'b0;
  logic       pll_reset;
  logic [5:0] pll_idsel, pll_fbdsel, pll_odsel;
  logic       locked, busy, err;
  logic [7:0] relock_cnt;

  always #5 clkin = ~clkin;

  pll_dyn_ctrl #(
    .RST_CYCLES(4),
    .LOCK_TIMEOUT(50),
    .LOCK_STABLE(8),
    .MAX_RETRY(2)
  ) dut (
    .clkin(clkin),
    .reset(reset),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_idsel(cfg_idsel),
    .cfg_fbdsel(cfg_fbdsel),
    .cfg_odsel(cfg_odsel),
    .pll_lock(pll_lock),
    .pll_reset(pll_reset),
    .pll_idsel(pll_idsel),
    .pll_fbdsel(pll_fbdsel),
    .pll_odsel(pll_odsel),
    .locked(locked),
    .busy(busy),
    .err(err),
    .relock_cnt(relock_cnt)
  );

  typedef enum int {EV_RFALL, EV_LRISE, EV_ERISE} ev_kind_t;

  typedef struct {
    ev_kind_t    kind;
    int          val;
    logic [17:0] codes;
    logic [7:0]  rc;
    logic        er;
  } ev_t;

  typedef struct packed {
    logic        pr;
    logic [17:0] codes;
    logic        lk;
    logic        bsy;
    logic        er;
    logic        rdy;
    logic [7:0]  rc;
  } snap_t;

  ev_t   evq[$];
  snap_t snq[$];
  int    total = 0;
  int    bad = 0;

  int lk_off = 0;
  bit lk_never = 1'b0;
  bit lk_glitch = 1'b0;
  int drop_cnt = 0;
  int drop_seen = 0;
  bit dropped = 1'b0;
  int lk_cnt = 0;

  int   cyc = 0;
  int   hi_cnt = 0;
  int   fall_cyc = 0;
  logic p_pr, p_lk, p_er;

  function automatic logic [17:0] cc(input int a, input int b, input int c);
    logic [5:0] x, y, z;
    x = 6'(a);
    y = 6'(b);
    z = 6'(c);
    return {x, y, z};
  endfunction

  function automatic snap_t mk(input logic pr, input logic [17:0] c,
                               input logic lk, input logic bsy,
                               input logic er, input logic rdy,
                               input logic [7:0] rc);
    snap_t s;
    s.pr = pr;
    s.codes = c;
    s.lk = lk;
    s.bsy = bsy;
    s.er = er;
    s.rdy = rdy;
    s.rc = rc;
    return s;
  endfunction

  task automatic push_ev(input ev_kind_t k, input int v,
                         input logic [17:0] c, input int rc,
                         input logic er);
    ev_t e;
    e.kind = k;
    e.val = v;
    e.codes = c;
    e.rc = 8'(rc);
    e.er = er;
    evq.push_back(e);
  endtask

  task automatic check_ev(input ev_kind_t k, input int v);
    ev_t e;
    logic [17:0] ac;
    ac = {pll_idsel, pll_fbdsel, pll_odsel};
    total++;
    if (evq.size() == 0) begin
      bad++;
      $display("FAIL ev_%s unexpected at cycle %0d val=%0d", k.name(), cyc, v);
    end else begin
      e = evq.pop_front();
      if (e.kind != k || (e.val >= 0 && e.val != v) || e.codes !== ac ||
          e.rc !== relock_cnt || e.er !== err) begin
        bad++;
        $display("FAIL ev_%s got kind=%s val=%0d codes=%h rc=%0d err=%b want kind=%s val=%0d codes=%h rc=%0d err=%b",
                 k.name(), k.name(), v, ac, relock_cnt, err,
                 e.kind.name(), e.val, e.codes, e.rc, e.er);
      end
    end
  endtask

  // rPLL LOCK model: held low in reset, rises lk_off cycles after release
  initial begin
    forever begin
      @(negedge clkin);
      if (pll_reset !== 1'b0) begin
        lk_cnt = 0;
        dropped = 1'b0;
        pll_lock = 1'b0;
      end else if (drop_seen != drop_cnt) begin
        drop_seen = drop_cnt;
        dropped = 1'b1;
        pll_lock = 1'b0;
      end else if (dropped || lk_never) begin
        pll_lock = 1'b0;
      end else begin
        pll_lock = lk_glitch ? (lk_cnt >= lk_off && lk_cnt != lk_off + 5)
                             : (lk_cnt >= lk_off);
        lk_cnt++;
      end
    end
  end

  initial begin
    snap_t a, e;
    forever begin
      @(negedge clkin);
      cyc++;
      if (snq.size() != 0) begin
        e = snq.pop_front();
        a = {pll_reset, pll_idsel, pll_fbdsel, pll_odsel,
             locked, busy, err, cfg_ready, relock_cnt};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL snap cycle %0d got=%h want=%h", cyc, a, e);
        end
      end
      if (reset) hi_cnt = 0;
      else if (pll_reset === 1'b1) hi_cnt++;
      if (p_pr === 1'b1 && pll_reset === 1'b0) begin
        check_ev(EV_RFALL, hi_cnt);
        fall_cyc = cyc;
        hi_cnt = 0;
      end
      if (p_lk === 1'b0 && locked === 1'b1) check_ev(EV_LRISE, cyc - fall_cyc);
      if (p_er === 1'b0 && err === 1'b1) check_ev(EV_ERISE, cyc - fall_cyc);
      p_pr = pll_reset;
      p_lk = locked;
      p_er = err;
    end
  end

  task automatic tick;
    @(posedge clkin);
    #1;
  endtask

  function automatic logic sel(input int w);
    case (w)
      0: return locked;
      1: return pll_reset;
      default: return err;
    endcase
  endfunction

  task automatic wait_for(input int w, input logic v, input int max,
                          input string nm);
    for (int i = 0; i < max; i++) begin
      tick;
      if (sel(w) === v) return;
    end
    total++;
    bad++;
    $display("FAIL timeout_%s got=%b want=%b after %0d cycles", nm, sel(w), v, max);
  endtask

  task automatic offer(input int a, input int b, input int c);
    cfg_idsel = 6'(a);
    cfg_fbdsel = 6'(b);
    cfg_odsel = 6'(c);
    cfg_valid = 1'b1;
    tick;
    cfg_valid = 1'b0;
  endtask

  initial begin
    int rc;
    repeat (3) tick;
    snq.push_back(mk(1'b1, cc(0, 0, 0), 1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
    lk_off = 10;
    push_ev(EV_RFALL, 4, cc(0, 0, 0), 0, 1'b0);
    push_ev(EV_LRISE, 21, cc(0, 0, 0), 0, 1'b0);
    tick;
    reset = 1'b0;
    wait_for(0, 1'b1, 200, "powerup");

    lk_off = 0;
    push_ev(EV_RFALL, 4, cc(1, 3, 2), 0, 1'b0);
    push_ev(EV_LRISE, 11, cc(1, 3, 2), 0, 1'b0);
    offer(1, 3, 2);
    snq.push_back(mk(1'b1, cc(0, 0, 0), 1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
    tick;
    snq.push_back(mk(1'b1, cc(1, 3, 2), 1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
    wait_for(0, 1'b1, 200, "reconfig");

    lk_glitch = 1'b1;
    push_ev(EV_RFALL, 4, cc(4, 5, 6), 0, 1'b0);
    push_ev(EV_LRISE, 17, cc(4, 5, 6), 0, 1'b0);
    offer(4, 5, 6);
    wait_for(0, 1'b1, 200, "glitch");
    lk_glitch = 1'b0;

    for (int i = 0; i < 3; i++) begin
      push_ev(EV_RFALL, 4, cc(4, 5, 6), i + 1, 1'b0);
      push_ev(EV_LRISE, 11, cc(4, 5, 6), i + 1, 1'b0);
      drop_cnt++;
      if (i == 0) begin
        tick;
        tick;
        snq.push_back(mk(1'b0, cc(4, 5, 6), 1'b1, 1'b0, 1'b0, 1'b1, 8'd0));
        tick;
        snq.push_back(mk(1'b1, cc(4, 5, 6), 1'b0, 1'b1, 1'b0, 1'b0, 8'd1));
      end
      wait_for(0, 1'b0, 20, "loss_drop");
      wait_for(0, 1'b1, 200, "loss_relock");
    end

    lk_never = 1'b1;
    push_ev(EV_RFALL, 4, cc(7, 8, 9), 3, 1'b0);
    push_ev(EV_RFALL, 4, cc(7, 8, 9), 3, 1'b0);
    push_ev(EV_ERISE, 50, cc(7, 8, 9), 3, 1'b1);
    offer(7, 8, 9);
    wait_for(2, 1'b1, 300, "fail_err");
    snq.push_back(mk(1'b1, cc(7, 8, 9), 1'b0, 1'b0, 1'b1, 1'b1, 8'd3));
    tick;
    lk_never = 1'b0;
    push_ev(EV_RFALL, -1, cc(10, 11, 12), 3, 1'b0);
    push_ev(EV_LRISE, 11, cc(10, 11, 12), 3, 1'b0);
    offer(10, 11, 12);
    snq.push_back(mk(1'b1, cc(7, 8, 9), 1'b0, 1'b1, 1'b0, 1'b0, 8'd3));
    wait_for(0, 1'b1, 200, "fail_recover");

    for (int i = 0; i < 260; i++) begin
      rc = (4 + i > 255) ? 255 : 4 + i;
      push_ev(EV_RFALL, 4, cc(10, 11, 12), rc, 1'b0);
      push_ev(EV_LRISE, 11, cc(10, 11, 12), rc, 1'b0);
      drop_cnt++;
      wait_for(0, 1'b0, 20, "sat_drop");
      wait_for(0, 1'b1, 200, "sat_relock");
    end

    lk_never = 1'b1;
    push_ev(EV_RFALL, 4, cc(13, 14, 15), 255, 1'b0);
    offer(13, 14, 15);
    wait_for(1, 1'b0, 20, "mid_release");
    repeat (5) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    snq.push_back(mk(1'b1, cc(0, 0, 0), 1'b0, 1'b1, 1'b0, 1'b0, 8'd0));
    lk_never = 1'b0;
    push_ev(EV_RFALL, 4, cc(0, 0, 0), 0, 1'b0);
    push_ev(EV_LRISE, 11, cc(0, 0, 0), 0, 1'b0);
    wait_for(0, 1'b1, 200, "mid_relock");

    repeat (5) tick;
    total++;
    if (evq.size() != 0 || snq.size() != 0) begin
      bad++;
      $display("FAIL leftover got ev=%0d snap=%0d want 0", evq.size(), snq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
